// File: rtl/i2c_csr_v2_pkg.sv
// Shared register map, interrupt bit positions and CSR layouts for the
// second-generation I2C CSR front-end.
package i2c_csr_v2_pkg;

  localparam int unsigned CSR_CTRL     = 0;
  localparam int unsigned CSR_PRESCALE = 1;
  localparam int unsigned CSR_TX_DATA  = 2;
  localparam int unsigned CSR_RX_DATA  = 3;
  localparam int unsigned CSR_STATUS   = 4;
  localparam int unsigned CSR_IRQ_EN   = 5;
  localparam int unsigned CSR_IRQ_STAT = 6;
  localparam int unsigned CSR_PARAM    = 7;
  localparam int unsigned REG_NUM      = 8;

  localparam int unsigned IRQ_TX_EMPTY    = 0;
  localparam int unsigned IRQ_RX_NONEMPTY = 1;
  localparam int unsigned IRQ_RX_OVF      = 2;
  localparam int unsigned IRQ_TX_OVF_NACK = 3;

  typedef struct packed {
    logic irq_glob_en;
    logic en;
    logic rst;
  } i2c_ctrl_v2_reg_t;

  typedef struct packed {
    logic tx_ovf_nack;
    logic rx_ovf;
    logic rx_nonempty;
    logic tx_empty;
  } i2c_irq_reg_t;

  typedef struct packed {
    logic [7:0] rx_level;
    logic [7:0] tx_level;
    logic [9:0] rsvd;
    logic       rx_empty;
    logic       tx_empty;
    logic       rx_full;
    logic       tx_full;
    logic       nack_seen;
    logic       busy;
  } i2c_status_v2_reg_t;

  // Core held in soft reset until software releases it.
  localparam i2c_ctrl_v2_reg_t REG_INIT_V2 = '{irq_glob_en: 1'b0, en: 1'b0, rst: 1'b1};

endpackage

// File: rtl/i2c_csr_v2_sync_fifo.sv
// Single-clock FIFO with flush; level counts 0..DEPTH so full never aliases empty.
module i2c_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    cnt;
  logic             push_ok, pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/i2c_csr_v2.sv
// CSR block and TX/RX buffering between the register bus and the I2C bit engine,
// with W1C interrupt status, overflow/NACK capture and FIFO level reporting.
module i2c_csr_v2
  import i2c_csr_v2_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int PRESCALE_WIDTH = 16,
  parameter int ADDR_WIDTH     = 3
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic                      wr_en_i,
  input  logic [ADDR_WIDTH-1:0]     wr_addr_i,
  input  logic [31:0]               wr_data_i,
  input  logic                      rd_en_i,
  input  logic [ADDR_WIDTH-1:0]     rd_addr_i,
  output logic [31:0]               rd_data_o,
  output logic                      rd_valid_o,
  output logic                      core_rst_o,
  output logic                      core_en_o,
  output logic [PRESCALE_WIDTH-1:0] prescale_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [DATA_WIDTH-1:0]     tx_data_o,
  output logic                      tx_rw_o,
  input  logic                      rx_valid_i,
  input  logic [DATA_WIDTH-1:0]     rx_data_i,
  input  logic                      busy_i,
  input  logic                      nack_i,
  output logic                      irq_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  i2c_ctrl_v2_reg_t          ctrl;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [3:0]                irq_en, irq_stat, irq_stat_d, w1c;
  i2c_irq_reg_t              irq_set;
  logic                      nack_seen, irq_q;
  logic [31:0]               rd_mux;
  i2c_status_v2_reg_t        status;

  logic wr_ctrl, wr_pre, wr_tx, wr_irq_en, wr_irq_stat, rd_rx;
  assign wr_ctrl     = wr_en_i && (wr_addr_i == ADDR_WIDTH'(CSR_CTRL));
  assign wr_pre      = wr_en_i && (wr_addr_i == ADDR_WIDTH'(CSR_PRESCALE));
  assign wr_tx       = wr_en_i && (wr_addr_i == ADDR_WIDTH'(CSR_TX_DATA));
  assign wr_irq_en   = wr_en_i && (wr_addr_i == ADDR_WIDTH'(CSR_IRQ_EN));
  assign wr_irq_stat = wr_en_i && (wr_addr_i == ADDR_WIDTH'(CSR_IRQ_STAT));
  assign rd_rx       = rd_en_i && (rd_addr_i == ADDR_WIDTH'(CSR_RX_DATA));

  // FIFOs
  logic                  tx_push, tx_pop_ok, tx_full, tx_empty;
  logic                  rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_WIDTH:0]   tx_head;
  logic [DATA_WIDTH-1:0] rx_head;
  logic [LW-1:0]         tx_level, rx_level;

  assign tx_push   = wr_tx & ~ctrl.rst;
  assign tx_pop_ok = tx_ready_i & ~tx_empty;
  assign rx_push   = rx_valid_i & ~ctrl.rst;
  assign rx_pop    = rd_rx & ~rx_empty & ~ctrl.rst;

  i2c_sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i, .arstn_i, .flush(ctrl.rst), .push(tx_push), .pop(tx_ready_i),
    .wdata(wr_data_i[DATA_WIDTH:0]), .rdata(tx_head),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  i2c_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i, .arstn_i, .flush(ctrl.rst), .push(rx_push), .pop(rx_pop),
    .wdata(rx_data_i), .rdata(rx_head),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_head[DATA_WIDTH-1:0];
  assign tx_rw_o    = tx_head[DATA_WIDTH];

  // Interrupt events; a set in the same cycle as its W1C wins.
  assign irq_set = '{
    tx_ovf_nack: (tx_push & tx_full & ~tx_pop_ok) | nack_i,
    rx_ovf:      rx_push & rx_full & ~rx_pop,
    rx_nonempty: ~rx_empty,
    tx_empty:    tx_pop_ok & (tx_level == LW'(1)) & ~tx_push & ~ctrl.rst
  };
  assign w1c        = wr_irq_stat ? wr_data_i[3:0] : 4'b0;
  assign irq_stat_d = (irq_stat & ~w1c) | irq_set;

  assign status = '{
    rx_level:  8'(rx_level),
    tx_level:  8'(tx_level),
    rsvd:      '0,
    rx_empty:  rx_empty,
    tx_empty:  tx_empty,
    rx_full:   rx_full,
    tx_full:   tx_full,
    nack_seen: nack_seen,
    busy:      busy_i
  };

  always_comb begin
    rd_mux = '0;
    case (rd_addr_i)
      ADDR_WIDTH'(CSR_CTRL):     rd_mux = {29'b0, ctrl};
      ADDR_WIDTH'(CSR_PRESCALE): rd_mux = 32'(prescale);
      ADDR_WIDTH'(CSR_RX_DATA):  rd_mux = rx_empty ? '0 : 32'(rx_head);
      ADDR_WIDTH'(CSR_STATUS):   rd_mux = status;
      ADDR_WIDTH'(CSR_IRQ_EN):   rd_mux = {28'b0, irq_en};
      ADDR_WIDTH'(CSR_IRQ_STAT): rd_mux = {28'b0, irq_stat};
      ADDR_WIDTH'(CSR_PARAM):    rd_mux = {8'b0, 8'(FIFO_DEPTH), 8'(REG_NUM), 8'(DATA_WIDTH)};
      default:                   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ctrl       <= REG_INIT_V2;
      prescale   <= '0;
      irq_en     <= '0;
      irq_stat   <= '0;
      nack_seen  <= 1'b0;
      irq_q      <= 1'b0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      if (wr_ctrl)   ctrl     <= i2c_ctrl_v2_reg_t'(wr_data_i[2:0]);
      if (wr_pre)    prescale <= wr_data_i[PRESCALE_WIDTH-1:0];
      if (wr_irq_en) irq_en   <= wr_data_i[3:0];
      irq_stat   <= irq_stat_d;
      nack_seen  <= (nack_seen & ~w1c[IRQ_TX_OVF_NACK]) | nack_i;
      irq_q      <= ctrl.irq_glob_en & |(irq_stat & irq_en);
      rd_valid_o <= rd_en_i;
      rd_data_o  <= rd_en_i ? rd_mux : '0;
    end
  end

  assign core_rst_o = ctrl.rst;
  assign core_en_o  = ctrl.en;
  assign prescale_o = prescale;
  assign irq_o      = irq_q;

  // Upper write-data bits have no destination in any register.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data_i;

endmodule

// File: tb/tb_i2c_csr_v2.sv
// Randomized bench for i2c_csr_v2 against a queue-based transaction model.
module tb_i2c_csr_v2;
  localparam int DW = 8, DEPTH = 16, PW = 16, AW = 3;

  logic          clk_i = 1'b0, arstn_i = 1'b0;
  logic          wr_en_i = 1'b0, rd_en_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0, rd_addr_i = '0;
  logic [31:0]   wr_data_i = '0, rd_data_o;
  logic          rd_valid_o, core_rst_o, core_en_o;
  logic [PW-1:0] prescale_o;
  logic          tx_valid_o, tx_ready_i = 1'b0, tx_rw_o;
  logic [DW-1:0] tx_data_o, rx_data_i = '0;
  logic          rx_valid_i = 1'b0, busy_i = 1'b0, nack_i = 1'b0, irq_o;

  i2c_csr_v2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .core_rst_o(core_rst_o), .core_en_o(core_en_o),
    .prescale_o(prescale_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_data_o(tx_data_o), .tx_rw_o(tx_rw_o), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .busy_i(busy_i), .nack_i(nack_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0, checks = 0;

  // Reference model: register values plus FIFO contents as queues.
  logic [DW:0]   tx_q[$];
  logic [DW-1:0] rx_q[$];
  logic [2:0]    m_ctrl = 3'b001;
  logic [PW-1:0] m_pre = '0;
  logic [3:0]    m_en = '0, m_stat = '0;
  logic          m_nack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic irq_model();
    return m_ctrl[2] & |(m_stat & m_en);
  endfunction

  function automatic logic [31:0] status_model();
    return {8'(rx_q.size()), 8'(tx_q.size()), 10'b0, rx_q.size() == 0, tx_q.size() == 0,
            rx_q.size() == DEPTH, tx_q.size() == DEPTH, m_nack, busy_i};
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic settle();
    tick(); tick();
    if (rx_q.size() != 0) m_stat[1] = 1'b1;
  endtask

  task automatic model_write(input int a, input logic [31:0] d);
    case (a)
      0: begin m_ctrl = d[2:0]; if (m_ctrl[0]) begin tx_q.delete(); rx_q.delete(); end end
      1: m_pre = d[PW-1:0];
      2: if (!m_ctrl[0]) begin
           if (tx_q.size() == DEPTH) m_stat[3] = 1'b1; else tx_q.push_back(d[DW:0]);
         end
      5: m_en = d[3:0];
      6: begin m_stat = m_stat & ~d[3:0]; if (d[3]) m_nack = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = AW'(a); wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
    model_write(a, d);
    if (m_ctrl[0]) begin tx_q.delete(); rx_q.delete(); end
    settle();
  endtask

  task automatic rd_check(input string tag, input int a);
    logic [31:0] e;
    case (a)
      0: e = {29'b0, m_ctrl};
      1: e = 32'(m_pre);
      3: e = (rx_q.size() == 0) ? 32'h0 : 32'(rx_q.pop_front());
      4: e = status_model();
      5: e = {28'b0, m_en};
      6: e = {28'b0, m_stat};
      7: e = 32'h0010_0808;
      default: e = 32'h0;
    endcase
    rd_en_i = 1'b1; rd_addr_i = AW'(a);
    tick();
    rd_en_i = 1'b0;
    check({tag, "_vld"}, 32'(rd_valid_o), 32'h1);
    check(tag, rd_data_o, e);
    settle();
  endtask

  task automatic tx_take(input logic with_wr, input logic [31:0] d);
    logic popped;
    check("tx_valid", 32'(tx_valid_o), 32'(tx_q.size() != 0));
    if (tx_q.size() != 0) check("tx_head", 32'({tx_rw_o, tx_data_o}), 32'(tx_q[0]));
    tx_ready_i = 1'b1;
    if (with_wr) begin wr_en_i = 1'b1; wr_addr_i = AW'(2); wr_data_i = d; end
    tick();
    tx_ready_i = 1'b0; wr_en_i = 1'b0;
    popped = (tx_q.size() != 0);
    if (popped) void'(tx_q.pop_front());
    if (with_wr) model_write(2, d);
    if (popped && tx_q.size() == 0) m_stat[0] = 1'b1;
    settle();
  endtask

  task automatic rx_push(input logic [DW-1:0] d);
    rx_valid_i = 1'b1; rx_data_i = d;
    tick();
    rx_valid_i = 1'b0;
    if (!m_ctrl[0]) begin
      if (rx_q.size() == DEPTH) m_stat[2] = 1'b1; else rx_q.push_back(d);
    end
    settle();
  endtask

  task automatic nack_op(input logic do_w1c, input logic [3:0] w);
    logic prev;
    prev = irq_model();
    nack_i = 1'b1;
    if (do_w1c) begin wr_en_i = 1'b1; wr_addr_i = AW'(6); wr_data_i = 32'(w); end
    tick();
    nack_i = 1'b0; wr_en_i = 1'b0;
    if (do_w1c) model_write(6, 32'(w));
    m_stat[3] = 1'b1; m_nack = 1'b1;
    check("irq_o_pre", 32'(irq_o), 32'(prev));
    tick();
    check("irq_o_post", 32'(irq_o), 32'(irq_model()));
    tick();
    if (rx_q.size() != 0) m_stat[1] = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int          op;
    logic [3:0]  old_en;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rd_valid", 32'(rd_valid_o), 32'h0);
    check("rst_rd_data", rd_data_o, 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    check("rst_core_rst", 32'(core_rst_o), 32'h1);
    check("rst_prescale", 32'(prescale_o), 32'h0);
    arstn_i = 1'b1;
    tick();
    rd_check("rst_ctrl", 0);
    rd_check("rst_param", 7);
    rd_check("rst_stat", 6);
    rd_check("rst_status", 4);

    bus_write(0, 32'h6);
    check("core_rst_rel", 32'(core_rst_o), 32'h0);
    check("core_en", 32'(core_en_o), 32'h1);
    d = $urandom;
    bus_write(1, d);
    check("prescale_o", 32'(prescale_o), 32'(d[PW-1:0]));
    rd_check("prescale", 1);

    // Three commands held back, then streamed in order.
    repeat (3) bus_write(2, 32'h1A5);
    rd_check("status_tx3", 4);
    repeat (3) tx_take(1'b0, 32'h0);
    rd_check("stat_txempty", 6);
    bus_write(6, 32'hF);

    // TX fill, overflow, W1C, simultaneous push+pop at full, drain.
    repeat (17) bus_write(2, {$urandom_range(1, 0), 8'($urandom)});
    rd_check("status_txfull", 4);
    rd_check("stat_txovf", 6);
    bus_write(6, 32'h8);
    rd_check("stat_w1c", 6);
    tx_take(1'b1, 32'h0C3);
    rd_check("status_txpp", 4);
    repeat (DEPTH) tx_take(1'b0, 32'h0);
    bus_write(6, 32'hF);

    // RX overflow with rx_ovf interrupt enabled.
    bus_write(5, 32'h4);
    for (int i = 0; i < 17; i++) rx_push(DW'(i));
    rd_check("stat_rxovf", 6);
    check("irq_rxovf", 32'(irq_o), 32'(irq_model()));
    for (int i = 0; i < 17; i++) rd_check("rx_data", 3);
    bus_write(6, 32'hF);
    check("irq_clr", 32'(irq_o), 32'(irq_model()));

    // NACK capture; W1C colliding with a new NACK keeps the bit.
    bus_write(5, 32'h8);
    nack_op(1'b0, 4'h0);
    rd_check("status_nack", 4);
    nack_op(1'b1, 4'h8);
    rd_check("stat_nack_w1c", 6);
    bus_write(6, 32'h8);
    rd_check("status_nack_clr", 4);
    check("irq_nack_clr", 32'(irq_o), 32'(irq_model()));

    // Soft reset flushes both FIFOs, CSRs retained.
    repeat (5) bus_write(2, 32'($urandom_range(511, 0)));
    repeat (3) rx_push(DW'($urandom));
    bus_write(0, 32'h1);
    rd_check("status_flush", 4);
    rd_check("prescale_keep", 1);
    bus_write(0, 32'h6);
    bus_write(6, 32'hF);

    // Same-address read and write: read returns the old value.
    old_en = m_en;
    rd_en_i = 1'b1; rd_addr_i = AW'(5); wr_en_i = 1'b1; wr_addr_i = AW'(5); wr_data_i = 32'h5;
    tick();
    rd_en_i = 1'b0; wr_en_i = 1'b0;
    check("rw_same_old", rd_data_o, {28'b0, old_en});
    m_en = 4'h5;
    settle();
    rd_check("rw_same_new", 5);

    for (int n = 0; n < 300; n++) begin
      busy_i = 1'($urandom);
      op = $urandom_range(10, 0);
      case (op)
        0, 1: bus_write(2, 32'($urandom_range(511, 0)));
        2:    tx_take(1'($urandom), 32'($urandom_range(511, 0)));
        3, 4: rx_push(DW'($urandom));
        5:    rd_check("r_rx", 3);
        6: begin
          case ($urandom_range(4, 0))
            0: rd_check("r_ctrl", 0);
            1: rd_check("r_pre", 1);
            2: rd_check("r_status", 4);
            3: rd_check("r_en", 5);
            default: rd_check("r_stat", 6);
          endcase
        end
        7:    bus_write(6, 32'($urandom_range(15, 0)));
        8:    bus_write(5, 32'($urandom_range(15, 0)));
        9:    nack_op(1'($urandom), 4'($urandom));
        default: bus_write(0, {29'b0, 1'($urandom), 2'b10});
      endcase
      check("r_irq", 32'(irq_o), 32'(irq_model()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
